arb2_sel_gen: RTL and testbench
===============================

# arb2_sel_gen

Two-input round-robin arbiter that generates the select for the practice 2-to-1 mux stage and registers the selected data for the downstream consumer. Two producers present data with valid/ready handshakes. The block chooses one producer, drives `sel` exactly as a 2:1 mux select (0 = in0, 1 = in1), and captures the chosen word into a one-entry output register. A burst limit prevents one producer from starving the other.

## Interface
- `DW`, 8: data width of both inputs and the output.
- `MAX_BURST`, 4: maximum consecutive transfers from one input while the other input is requesting. Legal range is 1..15.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `in0_valid`  input  1  producer 0 has a word.
- `in0_data`  input  DW  producer 0 word.
- `in0_ready`  output  1  word on in0 is taken this cycle.
- `in1_valid`  input  1  producer 1 has a word.
- `in1_data`  input  DW  producer 1 word.
- `in1_ready`  output  1  word on in1 is taken this cycle.
- `sel`  output  1  registered mux select (0 = in0, 1 = in1).
- `out_valid`  output  1  output register holds a word.
- `out_data`  output  DW  registered selected word.
- `out_ready`  input  1  consumer takes the output word.

One clock domain. Reset is asynchronous and active-high; all registers clear immediately when `rst` rises.

## Operation
- **States:**
  - IDLE: no grant.
  - G0: in0 granted.
  - G1: in1 granted.
- **sel:**
  - 0 in G0, 1 in G1.
  - Holds its last value in IDLE.
- **Round-robin pointer `last`:** records the last granted input. On a tie, the input that is not `last` wins.
- **IDLE:**
  - Both valid: go to G(~last).
  - Only inX valid: go to GX.
  - Neither valid: stay in IDLE.
  - Both readies are 0 in IDLE.
- **GX:**
  - `inX_ready` = `~out_valid | out_ready`.
  - The other ready is 0.
  - A transfer occurs when `inX_valid & inX_ready`.
- **Transfer:**
  - `out_data` <= `inX_data`, `out_valid` <= 1.
  - `burst_cnt` increments.
- **Drain:** `out_valid` clears on `out_ready` when there is no same-cycle transfer.
- **Leaving GX:**
  - If `inX_valid` = 0 at the edge: go to GY if `inY_valid`, else IDLE.
  - If a transfer makes `burst_cnt` reach MAX_BURST and `inY_valid` = 1: go to GY.
  - If the burst limit is hit but `inY_valid` = 0: stay in GX and clear `burst_cnt`.
- **Every grant change:** `burst_cnt` <= 0 and `last` <= the new grant.
- **Arithmetic:** `burst_cnt` is 4 bits and never exceeds MAX_BURST.
- **Data integrity:** no word is duplicated or dropped. Each input's order is preserved.

## Timing
- **Reset values:**
  - State IDLE, `sel` = 0, `last` = 1 (in0 wins the first tie), `burst_cnt` = 0.
  - `out_valid` = 0, `out_data` = 0, `in0_ready` = `in1_ready` = 0.
- **Latency:**
  - `inX_valid` rises in IDLE at cycle 0.
  - Grant and `sel` are valid at cycle 1, where `inX_ready` = 1 if the output is empty.
  - `out_valid` rises at cycle 2.
- **Steady state:** one word per cycle while `out_ready` = 1 and the granted input keeps `valid` high.
- **Back-pressure:**
  - `out_valid=1` and `out_ready=0` forces `inX_ready` = 0.
  - `out_data` and `out_valid` hold stable.
  - The granted input must hold its data.
- **Same-cycle drain and load:** `out_valid` stays 1 and `out_data` takes the new word.
- **Switch cost:** a grant change takes effect at the next edge. The new input's first `ready` comes one cycle after the switch decision.
- **Ready paths:** `in*_ready` are combinational from the state, `out_valid` and `out_ready`. There is no path from `in*_valid` to `in*_ready`.
- **Reset mid-operation:**
  - The held word is discarded.
  - `out_valid` drops asynchronously.
  - No ready pulses are issued until the block is back in IDLE.

## Test plan
- **Reset:** assert `rst` mid-transfer with `out_valid`=1 -> `out_valid`=0 and `sel`=0 immediately, and state IDLE after release.
- **Single producer:** in0 streams 0x11,0x22,0x33 with `out_ready`=1 -> `sel`=0, outputs 0x11,0x22,0x33 starting 2 cycles after first valid, then IDLE after `in0_valid` drops.
- **Tie after reset:** both valid at the same cycle, in0 0xA0.., in1 0xB0.. (MAX_BURST=4) -> 4 words of in0, `sel` goes to 1, 4 words of in1, then back to in0. The output order is A0,A1,A2,A3,B0,B1,B2,B3,A4….
- **Burst limit with no contention:** in1 alone sends 10 words -> `sel` stays 1 and all 10 words arrive in order with no gap cycles.
- **Back-pressure:** hold `out_ready`=0 for 3 cycles with `out_valid`=1 -> `out_data` is unchanged, `in_ready`=0, and no loss or duplication after release.
- **Handover on drop:** in0 granted and its valid drops while in1 is valid -> G1 at the next edge and `sel`=1. The first in1 word appears at the output 2 cycles after the drop.

Source files
------------

// File: rtl/arb2_sel_gen_if.sv
// Handshake bundle between two producers, the arbiter and the downstream consumer.
// The producer/consumer side uses master; the arbiter uses slave.
interface arb2_sel_gen_if #(
   parameter int DW = 8
);
   logic          in0_valid;
   logic [DW-1:0] in0_data;
   logic          in0_ready;
   logic          in1_valid;
   logic [DW-1:0] in1_data;
   logic          in1_ready;
   logic          sel;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;

   modport master (
      output in0_valid,
      output in0_data,
      input  in0_ready,
      output in1_valid,
      output in1_data,
      input  in1_ready,
      input  sel,
      input  out_valid,
      input  out_data,
      output out_ready
   );

   modport slave (
      input  in0_valid,
      input  in0_data,
      output in0_ready,
      input  in1_valid,
      input  in1_data,
      output in1_ready,
      output sel,
      output out_valid,
      output out_data,
      input  out_ready
   );
endinterface

// File: rtl/arb2_sel_gen.sv
// Two-input round-robin arbiter with burst limit; drives a 2:1 mux select and
// registers the chosen word in a one-entry output stage.
//
//   state  | meaning
//   S_IDLE | no grant, both readies low, sel holds
//   S_G0   | in0 granted, sel = 0
//   S_G1   | in1 granted, sel = 1
module arb2_sel_gen #(
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst,
   arb2_sel_gen_if.slave bus
);

   if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
      $error("arb2_sel_gen: MAX_BURST must be in 1..15");
   end

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_G0   = 2'd1;
   localparam logic [1:0] S_G1   = 2'd2;

   localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic          last;
   logic [3:0]    burst_cnt;
   logic [3:0]    burst_nxt;
   logic [3:0]    burst_inc;
   logic          sel_r;
   logic          out_valid_r;
   logic [DW-1:0] out_data_r;

   logic          can_load;
   logic          ready0;
   logic          ready1;
   logic          xfer0;
   logic          xfer1;
   logic          xfer;
   logic          limit_hit;
   logic [DW-1:0] xfer_data;
   logic          grant_change;

   // Output stage accepts a word when empty or being drained this cycle.
   assign can_load  = ~out_valid_r | bus.out_ready;
   assign ready0    = (state == S_G0) & can_load;
   assign ready1    = (state == S_G1) & can_load;
   assign xfer0     = ready0 & bus.in0_valid;
   assign xfer1     = ready1 & bus.in1_valid;
   assign xfer      = xfer0 | xfer1;
   assign xfer_data = xfer1 ? bus.in1_data : bus.in0_data;
   assign burst_inc = burst_cnt + 4'd1;
   assign limit_hit = xfer & (burst_inc == BURST_LIMIT);

   always_comb begin
      state_nxt = state;
      burst_nxt = burst_cnt;
      case (state)
         S_IDLE: begin
            if (bus.in0_valid && bus.in1_valid) begin
               state_nxt = last ? S_G0 : S_G1;
            end else if (bus.in0_valid) begin
               state_nxt = S_G0;
            end else if (bus.in1_valid) begin
               state_nxt = S_G1;
            end
         end
         S_G0: begin
            if (!bus.in0_valid) begin
               state_nxt = bus.in1_valid ? S_G1 : S_IDLE;
            end else if (limit_hit) begin
               if (bus.in1_valid) begin
                  state_nxt = S_G1;
               end else begin
                  burst_nxt = 4'd0;
               end
            end else if (xfer0) begin
               burst_nxt = burst_inc;
            end
         end
         S_G1: begin
            if (!bus.in1_valid) begin
               state_nxt = bus.in0_valid ? S_G0 : S_IDLE;
            end else if (limit_hit) begin
               if (bus.in0_valid) begin
                  state_nxt = S_G0;
               end else begin
                  burst_nxt = 4'd0;
               end
            end else if (xfer1) begin
               burst_nxt = burst_inc;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            burst_nxt = 4'd0;
         end
      endcase
      if (state_nxt != state) begin
         burst_nxt = 4'd0;
      end
   end

   // Dropping to IDLE is a grant change for the counter, but keeps last/sel.
   assign grant_change = (state_nxt != state) && (state_nxt != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         burst_cnt <= 4'd0;
         last      <= 1'b1;
         sel_r     <= 1'b0;
      end else begin
         state     <= state_nxt;
         burst_cnt <= burst_nxt;
         if (grant_change) begin
            last  <= (state_nxt == S_G1);
            sel_r <= (state_nxt == S_G1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
      end else if (xfer) begin
         out_valid_r <= 1'b1;
         out_data_r  <= xfer_data;
      end else if (bus.out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   assign bus.in0_ready = ready0;
   assign bus.in1_ready = ready1;
   assign bus.sel       = sel_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;

endmodule

// File: tb/tb_arb2_sel_gen.sv
// Directed bench for arb2_sel_gen: a cycle model derived from the arbitration
// rules is compared every cycle, and literal expectations pin each scenario.
module tb_arb2_sel_gen;
   localparam int DW = 8;
   localparam int MB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   arb2_sel_gen_if #(.DW(DW)) bus ();

   arb2_sel_gen #(.DW(DW), .MAX_BURST(MB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   byte unsigned q0[$];
   byte unsigned q1[$];
   byte unsigned got[$];
   int           got_cyc[$];
   bit           en0 = 0, en1 = 0, ordy = 1, take0 = 0, take1 = 0;

   // model state: grant -1 = none, 0/1 = input index
   int          m_g    = -1;
   int          m_cnt  = 0;
   bit          m_last = 1'b1;
   bit          m_sel  = 1'b0;
   bit          m_ov   = 1'b0;
   logic [7:0]  m_od   = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_got(input string name, input byte unsigned exp[$]);
      chk({name, " count"}, got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         chk($sformatf("%s word%0d", name, i), got[i], exp[i]);
      end
   endtask

   initial begin : model
      int  ng, nc;
      bit  v[2];
      logic [7:0] d[2];
      bit  tk;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_g = -1; m_cnt = 0; m_last = 1'b1; m_sel = 1'b0; m_ov = 1'b0; m_od = 8'h00;
         end else begin
            v[0] = bus.in0_valid; v[1] = bus.in1_valid;
            d[0] = bus.in0_data;  d[1] = bus.in1_data;
            tk = (m_g >= 0) && v[m_g] && (!m_ov || bus.out_ready);
            if (tk) begin
               m_od = d[m_g];
               m_ov = 1'b1;
            end else if (bus.out_ready) begin
               m_ov = 1'b0;
            end
            ng = m_g;
            nc = m_cnt;
            if (m_g < 0) begin
               if (v[0] && v[1]) ng = m_last ? 0 : 1;
               else if (v[0])    ng = 0;
               else if (v[1])    ng = 1;
            end else if (!v[m_g]) begin
               ng = v[1 - m_g] ? 1 - m_g : -1;
            end else if (tk) begin
               nc = m_cnt + 1;
               if (nc == MB) begin
                  nc = 0;
                  if (v[1 - m_g]) ng = 1 - m_g;
               end
            end
            if (ng != m_g) begin
               nc = 0;
               if (ng >= 0) begin
                  m_last = (ng == 1);
                  m_sel  = (ng == 1);
               end
            end
            m_g   = ng;
            m_cnt = nc;
         end
         if (!rst) cyc++;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("in0_ready", bus.in0_ready, (m_g == 0) && (!m_ov || bus.out_ready));
         chk("in1_ready", bus.in1_ready, (m_g == 1) && (!m_ov || bus.out_ready));
         chk("sel",       bus.sel,       m_sel);
         chk("out_valid", bus.out_valid, m_ov);
         chk("out_data",  bus.out_data,  m_od);
      end
   end

   // Advance one cycle: retire accepted words, drive inputs, sample at negedge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (take0 && q0.size() > 0) void'(q0.pop_front());
      if (take1 && q1.size() > 0) void'(q1.pop_front());
      bus.in0_valid = en0 && (q0.size() > 0);
      bus.in0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
      bus.in1_valid = en1 && (q1.size() > 0);
      bus.in1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
      bus.out_ready = ordy;
      @(negedge clk);
      take0 = bus.in0_valid & bus.in0_ready;
      take1 = bus.in1_valid & bus.in1_ready;
      if (!rst && bus.out_valid && bus.out_ready) begin
         got.push_back(bus.out_data);
         got_cyc.push_back(cyc);
      end
   endtask

   task automatic drain(input int limit);
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || bus.out_valid) && n < limit) begin
         tick();
         n++;
      end
      checks++;
      if (n >= limit) begin
         failures++;
         $display("FAIL drain timeout: q0=%0d q1=%0d out_valid=%0b", q0.size(), q1.size(), bus.out_valid);
      end
      tick();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 rst = 1'b1;
      en0 = 0; en1 = 0; ordy = 1; take0 = 0; take1 = 0;
      q0.delete(); q1.delete();
      bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      got.delete(); got_cyc.delete();
   endtask

   initial begin : watchdog
      #200000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : stim
      byte unsigned held;
      bus.in0_valid = 1'b0; bus.in0_data = 8'h00;
      bus.in1_valid = 1'b0; bus.in1_data = 8'h00;
      bus.out_ready = 1'b1;

      // reset values while rst is held
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst out_valid", bus.out_valid, 0);
      chk("rst out_data",  bus.out_data,  0);
      chk("rst in0_ready", bus.in0_ready, 0);
      chk("rst in1_ready", bus.in1_ready, 0);
      chk("rst sel",       bus.sel,       0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);

      // single producer latency and stream
      q0 = '{8'h11, 8'h22, 8'h33};
      en0 = 1;
      tick();
      chk("single c0 in0_ready", bus.in0_ready, 0);
      chk("single c0 out_valid", bus.out_valid, 0);
      tick();
      chk("single c1 sel", bus.sel, 0);
      chk("single c1 in0_ready", bus.in0_ready, 1);
      chk("single c1 out_valid", bus.out_valid, 0);
      tick();
      chk("single c2 out_valid", bus.out_valid, 1);
      chk("single c2 out_data", bus.out_data, 8'h11);
      drain(40);
      chk_got("single", '{8'h11, 8'h22, 8'h33});
      chk("single idle in0_ready", bus.in0_ready, 0);
      chk("single idle in1_ready", bus.in1_ready, 0);

      // tie right after reset, burst limit alternation
      do_reset();
      q0 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
      q1 = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
      en0 = 1; en1 = 1;
      drain(80);
      chk_got("tie", '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
                       8'hA4, 8'hA5, 8'hB4, 8'hB5});

      // burst limit without contention: no gaps
      got.delete(); got_cyc.delete();
      en0 = 0; en1 = 1;
      for (int i = 0; i < 10; i++) q1.push_back(byte'(8'h40 + i));
      drain(60);
      chk_got("burst", '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49});
      if (got_cyc.size() == 10) chk("burst span", got_cyc[9] - got_cyc[0], 9);
      chk("burst sel", bus.sel, 1);

      // back-pressure
      got.delete(); got_cyc.delete();
      en1 = 0; en0 = 1;
      q0 = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64};
      repeat (3) tick();
      ordy = 0;
      tick();
      held = bus.out_data;
      chk("bp held word", held, 8'h61);
      for (int i = 0; i < 3; i++) begin
         chk("bp out_data", bus.out_data, held);
         chk("bp out_valid", bus.out_valid, 1);
         chk("bp in0_ready", bus.in0_ready, 0);
         if (i < 2) tick();
      end
      ordy = 1;
      drain(40);
      chk_got("bp", '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64});

      // handover when the granted input drops valid
      got.delete(); got_cyc.delete();
      q0 = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
      q1 = '{8'hD0, 8'hD1};
      en0 = 1; en1 = 0;
      tick();
      tick();
      en1 = 1;
      tick();
      en0 = 0;
      tick();
      tick();
      chk("handover sel", bus.sel, 1);
      chk("handover in1_ready", bus.in1_ready, 1);
      tick();
      chk("handover out_valid", bus.out_valid, 1);
      chk("handover out_data", bus.out_data, 8'hD0);
      en0 = 1;
      drain(60);
      chk_got("handover", '{8'hC0, 8'hC1, 8'hD0, 8'hD1, 8'hC2, 8'hC3, 8'hC4, 8'hC5});

      // asynchronous reset with a held word
      got.delete(); got_cyc.delete();
      q1 = '{8'hE0, 8'hE1, 8'hE2, 8'hE3};
      en0 = 0; en1 = 1; ordy = 0;
      repeat (3) tick();
      chk("arst pre out_valid", bus.out_valid, 1);
      chk("arst pre sel", bus.sel, 1);
      #2 rst = 1'b1;
      en1 = 0; q1.delete(); take0 = 0; take1 = 0;
      bus.in1_valid = 1'b0;
      bus.out_ready = 1'b1;
      ordy = 1;
      #1;
      chk("arst out_valid", bus.out_valid, 0);
      chk("arst sel", bus.sel, 0);
      chk("arst in1_ready", bus.in1_ready, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("arst idle in0_ready", bus.in0_ready, 0);
      chk("arst idle in1_ready", bus.in1_ready, 0);
      chk("arst idle out_valid", bus.out_valid, 0);
      q0 = '{8'hF0};
      en0 = 1;
      drain(20);
      chk_got("after arst", '{8'hF0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
